// File: rtl/eq_axis_framer_if.sv
// AXI-Stream style handshake bundle used on both sides of the equalizer framer.
// The master drives data/valid/last; the slave answers with ready.
interface eq_axis_framer_if #(
  parameter int W = 24
) ();
  logic [W-1:0] tdata;
  logic         tvalid;
  logic         tready;
  logic         tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/eq_axis_framer.sv
// Packs pairs of audio samples into double-width words, frames them into fixed-length
// packages with tlast, and can zero-pad a partial package on request.
module eq_axis_framer #(
  parameter int DATA_WIDTH     = 24,
  parameter int PACKAGE_LENGTH = 1024,
  parameter int PKG_CNT_WIDTH  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  eq_axis_framer_if.slave          s00_axis,
  eq_axis_framer_if.master         m00_axis,
  input  logic                     flush,
  output logic [PKG_CNT_WIDTH-1:0] pkg_cnt,
  output logic                     busy
);

  localparam int WCW = (PACKAGE_LENGTH > 1) ? $clog2(PACKAGE_LENGTH) : 1;
  localparam logic [WCW-1:0] LAST_IDX = WCW'(PACKAGE_LENGTH - 1);

  typedef enum logic {
    RUN = 1'b0,
    PAD = 1'b1
  } state_t;

  state_t                    state_q, state_d;
  logic                      half_q, half_d;
  logic [DATA_WIDTH-1:0]     low_q, low_d;
  logic                      out_valid_q, out_valid_d;
  logic [2*DATA_WIDTH-1:0]   out_data_q, out_data_d;
  logic [WCW-1:0]            word_cnt_q, word_cnt_d;
  logic [PKG_CNT_WIDTH-1:0]  pkg_cnt_q, pkg_cnt_d;
  logic                      run_en_q;

  logic s_ready;
  logic in_hs;
  logic m_hs;
  logic last_word;
  logic can_load;

  // Registered enable keeps the input closed during reset and for the reset-release edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= RUN;
      half_q      <= 1'b0;
      low_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      word_cnt_q  <= '0;
      pkg_cnt_q   <= '0;
      run_en_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      half_q      <= half_d;
      low_q       <= low_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      word_cnt_q  <= word_cnt_d;
      pkg_cnt_q   <= pkg_cnt_d;
      run_en_q    <= 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    half_d      = half_q;
    low_d       = low_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    word_cnt_d  = word_cnt_q;
    pkg_cnt_d   = pkg_cnt_q;

    last_word = out_valid_q && (word_cnt_q == LAST_IDX);
    m_hs      = out_valid_q && m00_axis.tready;
    can_load  = !out_valid_q || m00_axis.tready;
    s_ready   = run_en_q && (state_q == RUN) && (!half_q || can_load);
    in_hs     = s_ready && s00_axis.tvalid;

    if (m_hs) begin
      out_valid_d = 1'b0;
      if (last_word) begin
        word_cnt_d = '0;
        pkg_cnt_d  = pkg_cnt_q + PKG_CNT_WIDTH'(1);
      end else begin
        word_cnt_d = word_cnt_q + WCW'(1);
      end
    end

    case (state_q)
      RUN: begin
        if (in_hs) begin
          if (!half_q) begin
            low_d  = s00_axis.tdata;
            half_d = 1'b1;
          end else begin
            out_data_d  = {s00_axis.tdata, low_q};
            out_valid_d = 1'b1;
            half_d      = 1'b0;
          end
        end
        // A sample arriving with the flush makes an otherwise idle framer worth padding.
        if (flush && (half_q || out_valid_q || (word_cnt_q != '0) || in_hs)) begin
          state_d = PAD;
        end
      end
      PAD: begin
        // A held half-sample always goes out, even if it starts the next package.
        if (can_load && (half_q || !last_word)) begin
          out_valid_d = 1'b1;
          out_data_d  = half_q ? {{DATA_WIDTH{1'b0}}, low_q} : '0;
          half_d      = 1'b0;
        end
        if (m_hs && last_word && !half_q) begin
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  assign s00_axis.tready = s_ready;
  assign m00_axis.tvalid = out_valid_q;
  assign m00_axis.tdata  = out_data_q;
  assign m00_axis.tlast  = last_word;
  assign pkg_cnt         = pkg_cnt_q;
  assign busy            = half_q | out_valid_q | (word_cnt_q != '0) | (state_q == PAD);

endmodule

// File: tb/tb_eq_axis_framer.sv
// Directed self-checking bench for eq_axis_framer: packing, framing, backpressure,
// flush padding and mid-package reset.
module tb_eq_axis_framer;

  localparam int DW      = 24;
  localparam int PKG_LEN = 1024;
  localparam int PCW     = 16;

  logic           clk;
  logic           rst;
  logic           flush;
  logic [PCW-1:0] pkg_cnt;
  logic           busy;

  eq_axis_framer_if #(.W(DW))   s_if ();
  eq_axis_framer_if #(.W(2*DW)) m_if ();

  eq_axis_framer #(
    .DATA_WIDTH     (DW),
    .PACKAGE_LENGTH (PKG_LEN),
    .PKG_CNT_WIDTH  (PCW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .s00_axis (s_if),
    .m00_axis (m_if),
    .flush    (flush),
    .pkg_cnt  (pkg_cnt),
    .busy     (busy)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  bit rand_ready   = 1'b0;
  bit ready_level  = 1'b1;
  bit bubble_watch = 1'b0;
  bit pad_watch    = 1'b0;
  int bubbles      = 0;
  int pad_viol     = 0;

  logic [2*DW:0]   got_q[$];
  logic [2*DW-1:0] exp_q[$];

  bit              prev_stall = 1'b0;
  logic [2*DW-1:0] prev_data;
  logic            prev_last;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Downstream ready: constant level or coin-flip backpressure, updated 1 ns after each edge.
  initial begin
    m_if.tready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      m_if.tready = rand_ready ? 1'($urandom_range(0, 1)) : ready_level;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp)
    else begin
      tests_failed++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Output monitor sampled mid-cycle: collects handshaken words and checks stall stability.
  always @(negedge clk) begin
    if (!rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_tvalid", m_if.tvalid, 1'b1);
        check("stall_tdata", m_if.tdata, prev_data);
        check("stall_tlast", m_if.tlast, prev_last);
      end
      if (m_if.tvalid && m_if.tready) got_q.push_back({m_if.tlast, m_if.tdata});
      prev_stall = m_if.tvalid && !m_if.tready;
      prev_data  = m_if.tdata;
      prev_last  = m_if.tlast;
      if (bubble_watch && s_if.tvalid && !s_if.tready) bubbles++;
      if (pad_watch && s_if.tready) pad_viol++;
    end
  end

  task automatic step();
    @(posedge clk);
    #3;
  endtask

  function automatic logic exp_last(input int idx);
    return (idx % PKG_LEN) == (PKG_LEN - 1);
  endfunction

  task automatic exp_pairs(input int first, input int n);
    for (int i = 0; i < n; i += 2) exp_q.push_back({DW'(first + i + 1), DW'(first + i)});
  endtask

  task automatic exp_pad();
    while ((exp_q.size() % PKG_LEN) != 0) exp_q.push_back('0);
  endtask

  task automatic do_reset();
    rst         = 1'b0;
    flush       = 1'b0;
    s_if.tvalid = 1'b0;
    rand_ready  = 1'b0;
    ready_level = 1'b1;
    step();
    step();
    rst = 1'b1;
    step();
    got_q.delete();
    exp_q.delete();
    bubbles  = 0;
    pad_viol = 0;
  endtask

  task automatic send(input int first, input int n, input bit flush_last);
    for (int i = 0; i < n; i++) begin
      int wait_c = 0;
      s_if.tdata  = DW'(first + i);
      s_if.tvalid = 1'b1;
      while (!s_if.tready && wait_c < 200) begin
        step();
        wait_c++;
      end
      if (!s_if.tready) check("send_ready_timeout", s_if.tready, 1'b1);
      if (flush_last && i == n - 1) flush = 1'b1;
      step();
      flush = 1'b0;
    end
    s_if.tvalid = 1'b0;
  endtask

  task automatic compare_words(input string tag, input int budget);
    int c = 0;
    int bad = 0;
    int first_bad = -1;
    while (got_q.size() < exp_q.size() && c < budget) begin
      step();
      c++;
    end
    check({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      if (got_q[i] !== {exp_last(i), exp_q[i]}) begin
        bad++;
        if (first_bad < 0) first_bad = i;
      end
    end
    check($sformatf("%s_mismatches_first_at_%0d", tag, first_bad), bad, 0);
  endtask

  initial begin
    rst         = 1'b0;
    flush       = 1'b0;
    s_if.tdata  = '0;
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;

    // Reset state
    step();
    step();
    step();
    check("rst_tvalid", m_if.tvalid, 1'b0);
    check("rst_tlast", m_if.tlast, 1'b0);
    check("rst_tdata", m_if.tdata, 48'h0);
    check("rst_pkg_cnt", pkg_cnt, 16'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_s_ready", s_if.tready, 1'b0);
    rst = 1'b1;
    step();
    check("release_s_ready", s_if.tready, 1'b1);

    // Samples 1..4 with latency checks
    got_q.delete();
    s_if.tdata  = 24'd1;
    s_if.tvalid = 1'b1;
    step();
    check("lat_tvalid_after_s1", m_if.tvalid, 1'b0);
    check("lat_busy_half", busy, 1'b1);
    s_if.tdata = 24'd2;
    step();
    check("lat_tvalid_after_s2", m_if.tvalid, 1'b1);
    check("lat_tdata_w0", m_if.tdata, 48'h000002_000001);
    s_if.tdata = 24'd3;
    step();
    s_if.tdata = 24'd4;
    step();
    check("lat_tdata_w1", m_if.tdata, 48'h000004_000003);
    s_if.tvalid = 1'b0;
    step();
    exp_q.delete();
    exp_pairs(1, 4);
    compare_words("four_samples", 20);

    // Full-rate ramp: one package, no input bubbles
    do_reset();
    bubble_watch = 1'b1;
    send(1, 2 * PKG_LEN, 1'b0);
    bubble_watch = 1'b0;
    exp_pairs(1, 2 * PKG_LEN);
    compare_words("ramp", 100);
    step();
    step();
    check("ramp_bubbles", bubbles, 0);
    check("ramp_pkg_cnt", pkg_cnt, 16'd1);
    check("ramp_busy_idle", busy, 1'b0);

    // Random downstream backpressure: same word sequence
    do_reset();
    rand_ready = 1'b1;
    send(1, 2 * PKG_LEN, 1'b0);
    exp_pairs(1, 2 * PKG_LEN);
    compare_words("backpressure", 2000);
    rand_ready  = 1'b0;
    ready_level = 1'b1;
    step();
    step();
    check("bp_pkg_cnt", pkg_cnt, 16'd1);

    // Five samples then flush: odd sample padded, zeros to package end
    do_reset();
    send(1, 5, 1'b0);
    flush = 1'b1;
    step();
    flush     = 1'b0;
    pad_watch = 1'b1;
    exp_pairs(1, 4);
    exp_q.push_back({24'd0, 24'd5});
    exp_pad();
    compare_words("flush5", 3000);
    pad_watch = 1'b0;
    step();
    step();
    check("flush5_pkg_cnt", pkg_cnt, 16'd1);
    check("flush5_pad_ready", pad_viol, 0);
    check("flush5_busy", busy, 1'b0);
    check("flush5_s_ready", s_if.tready, 1'b1);

    // Flush while idle is a no-op
    do_reset();
    check("idle_busy", busy, 1'b0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    step();
    step();
    step();
    check("idle_flush_words", got_q.size(), 0);
    check("idle_flush_pkg_cnt", pkg_cnt, 16'd0);
    check("idle_flush_busy", busy, 1'b0);

    // Flush with the first sample, plus a second flush during PAD
    send(7, 1, 1'b1);
    step();
    step();
    check("same_cycle_busy", busy, 1'b1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    exp_q.push_back({24'd0, 24'd7});
    exp_pad();
    compare_words("same_cycle_flush", 3000);
    for (int i = 0; i < 20; i++) step();
    check("single_pad_words", got_q.size(), PKG_LEN);
    check("single_pad_pkg_cnt", pkg_cnt, 16'd1);

    // Reset with a word pending and input stalled
    do_reset();
    ready_level = 1'b0;
    step();
    send(1, 3, 1'b0);
    check("pend_s_ready", s_if.tready, 1'b0);
    check("pend_tvalid", m_if.tvalid, 1'b1);
    check("pend_tdata", m_if.tdata, 48'h000002_000001);
    rst = 1'b0;
    step();
    check("mid_rst_tvalid", m_if.tvalid, 1'b0);
    check("mid_rst_tlast", m_if.tlast, 1'b0);
    check("mid_rst_tdata", m_if.tdata, 48'h0);
    check("mid_rst_pkg_cnt", pkg_cnt, 16'd0);
    check("mid_rst_busy", busy, 1'b0);
    rst         = 1'b1;
    ready_level = 1'b1;
    step();
    got_q.delete();
    exp_q.delete();
    check("post_rst_s_ready", s_if.tready, 1'b1);
    send(100, 2 * PKG_LEN, 1'b0);
    exp_pairs(100, 2 * PKG_LEN);
    compare_words("post_rst_ramp", 100);
    step();
    step();
    check("post_rst_pkg_cnt", pkg_cnt, 16'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/eq_axis_framer.md
# eq_axis_framer

Upstream feeder for the equalizer's AXI-Stream slave port. It accepts a stream of 24-bit audio samples and packs consecutive sample pairs into 48-bit words. It emits exactly PACKAGE_LENGTH words per package with a package-end marker. On request it zero-pads a partial package so the equalizer always receives complete packages.

## Interface
Parameters:
- DATA_WIDTH, 24, sample width; output word is 2*DATA_WIDTH
- PACKAGE_LENGTH, 1024, output words per package
- PKG_CNT_WIDTH, 16, width of the package counter

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-low reset
- s00_axis_tdata  in  DATA_WIDTH  input sample
- s00_axis_tvalid  in  1  input sample valid
- s00_axis_tready  out  1  framer can accept a sample
- m00_axis_tdata  out  2*DATA_WIDTH  packed word; connects to equalizer s01_axis_tdata
- m00_axis_tvalid  out  1  word valid
- m00_axis_tready  in  1  equalizer accepts word
- m00_axis_tlast  out  1  high on the last word of a package
- flush  in  1  single-cycle request to complete the current package with zero padding
- pkg_cnt  out  PKG_CNT_WIDTH  number of completed packages; wraps
- busy  out  1  a partial package or pending word exists

## Operation
- Packing:
  - First accepted sample of a pair goes into the low register; half flag set.
  - Second sample forms word {sample_n+1, sample_n}, with the first sample in bits [DATA_WIDTH-1:0].
  - That word loads into a one-entry output register; half flag clears.
- Output register:
  - m00_axis_tvalid is high while it holds a word.
  - m00_axis_tdata and m00_axis_tlast stay stable while tvalid=1 and tready=0.
- s00_axis_tready:
  - 0 in PAD state and during reset.
  - Otherwise 1 if half=0.
  - Otherwise 1 if half=1 and (output register empty or m00_axis_tready=1).
  - Net effect: no bubble at full rate.
- word_cnt:
  - Range 0..PACKAGE_LENGTH-1; increments on each output handshake.
  - m00_axis_tlast = (word_cnt == PACKAGE_LENGTH-1) for the word in the output register.
  - A tlast handshake resets word_cnt to 0 and increments pkg_cnt (modulo 2^PKG_CNT_WIDTH).
- States:
  - RUN: normal packing.
  - PAD: zero-fill; no input accepted.
- flush while in RUN:
  - If half=0, word_cnt=0 and the output register is empty: no-op.
  - Otherwise the request is latched and the state goes to PAD on the next cycle.
  - If an input handshake occurs in the same cycle, that sample is accepted first, then the flush applies.
- PAD:
  - If half=1, the held sample is emitted as {0, sample}.
  - Then all-zero words are loaded until the tlast word is handshaken.
  - Then return to RUN with word_cnt=0, half=0.
- flush while in PAD: ignored.
- busy = half OR m00_axis_tvalid OR (word_cnt != 0) OR (state == PAD).
- Reset (rst=0 at a clock edge):
  - Outputs go to 0: tvalid, tlast, tdata, pkg_cnt, busy, s00_axis_tready.
  - half, word_cnt and state go to RUN, with the flush request cleared.
  - Reset mid-package discards partial data without emitting a word.
  - s00_axis_tready rises the first cycle after rst=1.

## Timing
- Latency: second sample of a pair accepted at edge N -> m00_axis_tvalid=1 after edge N (visible cycle N+1).
- Throughput: one word per two input samples at 1 sample/cycle with m00_axis_tready held high.
- Backpressure:
  - Output full and m00_axis_tready=0 -> s00_axis_tready=0 when half=1; the input stalls after at most one further sample.
  - A new word may load in the same cycle the current one is handshaken.
- PAD emission: one zero word per cycle while m00_axis_tready=1.
- pkg_cnt updates on the edge of the tlast handshake; visible the next cycle.
- flush is sampled only on a clock edge; width > 1 cycle behaves as one request if PAD is entered on the first.

## Test plan
- Reset then stream samples 1,2,3,4 with m00_axis_tready=1:
  - Words 0x000002_000001 and 0x000004_000003.
  - First tvalid one cycle after sample 2 is accepted.
- Stream 2*PACKAGE_LENGTH samples (ramp):
  - 1024 words.
  - tlast only on word 1023.
  - pkg_cnt 0->1.
  - No s00_axis_tready bubbles.
- Random m00_axis_tready backpressure (50%):
  - Word sequence identical to the no-stall case.
  - tdata/tlast stable during stalls.
  - No sample lost or duplicated.
- Send 5 samples, then pulse flush:
  - Words {2,1}, {4,3}, {0,5}.
  - Then 1021 zero words, the last with tlast.
  - pkg_cnt increments.
  - s00_axis_tready=0 throughout PAD.
- flush with busy=0:
  - No words emitted; pkg_cnt unchanged.
  - flush in PAD or same-cycle flush+sample: sample included, single padding sequence.
- Assert rst after 3 samples (word 1 pending, tready=0):
  - tvalid/tlast/pkg_cnt=0 next cycle.
  - Fresh stream then starts a new package at word_cnt 0.
